data_bus_if: RTL and testbench

Multi-cycle data-memory bus interface directly downstream of the MEM stage. It consumes MEM's memory request (ce/we/sel/addr/data) and runs a req/ack handshake on the external data bus. It holds the pipeline through stallreq_o until the access completes, then returns the read word that MEM sign/zero-extends. It also handles pipeline flush mid-access and bus timeout.

---
 rtl/data_bus_if_if.sv | 13 +
 rtl/data_bus_if.sv | 82 ++++++++
 tb/tb_data_bus_if.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/data_bus_if_if.sv
// data_bus_if_if: external data-bus handshake signals shared by the bus master and the memory slave.
interface data_bus_if_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  sel;
   logic [31:0] wdata;
   logic        ack;
   logic [31:0] rdata;
   logic        err;
   modport master (output req, we, addr, sel, wdata, err, input ack, rdata);
   modport slave  (input req, we, addr, sel, wdata, err, output ack, rdata);
endinterface

// File: rtl/data_bus_if.sv
// data_bus_if: turns MEM-stage requests into req/ack bus accesses, stalling the pipeline until completion,
// with flush draining and timeout abort.
module data_bus_if #(
   parameter int TIMEOUT = 16,
   parameter int CW      = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          mem_ce_i,
   input  logic          mem_we_i,
   input  logic [3:0]    mem_sel_i,
   input  logic [31:0]   mem_addr_i,
   input  logic [31:0]   mem_data_i,
   input  logic          flush_i,
   output logic [31:0]   mem_data_o,
   output logic          stallreq_o,
   data_bus_if_if.master bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] WAIT  = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;
   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [31:0]   rdq;
   logic          go;
   logic          tmo;
   logic          unused_lsb;
   assign unused_lsb = ^mem_addr_i[1:0];
   always_comb begin
      go         = mem_ce_i & ~flush_i;
      tmo        = cnt == CW'(TIMEOUT - 1);
      // gated by rst so the stall also vanishes the instant reset asserts
      stallreq_o = rst & ((state == IDLE || state == DRAIN) ? go : (state == WAIT) & ~flush_i);
      mem_data_o = (state == DONE) ? rdq : '0;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         rdq       <= '0;
         bus.req   <= 1'b0;
         bus.we    <= 1'b0;
         bus.addr  <= '0;
         bus.sel   <= '0;
         bus.wdata <= '0;
         bus.err   <= 1'b0;
      end else begin
         bus.err <= 1'b0;
         case (state)
            IDLE: if (go) begin
               bus.req   <= 1'b1;
               bus.we    <= mem_we_i;
               bus.addr  <= {mem_addr_i[31:2], 2'b00};
               bus.sel   <= mem_sel_i;
               bus.wdata <= mem_data_i;
               cnt       <= '0;
               state     <= WAIT;
            end
            WAIT: begin
               cnt <= cnt + 1'b1;
               if (bus.ack | tmo) begin
                  bus.req <= 1'b0;
                  rdq     <= (bus.ack & ~bus.we) ? bus.rdata : '0;
                  bus.err <= ~bus.ack & ~flush_i;
                  state   <= flush_i ? IDLE : DONE;
               end else if (flush_i) begin
                  state <= DRAIN;
               end
            end
            DONE: state <= IDLE;
            default: begin
               cnt <= cnt + 1'b1;
               if (bus.ack | tmo) begin
                  bus.req <= 1'b0;
                  state   <= IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_data_bus_if.sv
// tb_data_bus_if: scoreboard bench for data_bus_if covering load, store, timeout, flush/drain and async reset.
module tb_data_bus_if;
   localparam int TO = 16;
   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_ce_i = 1'b0;
   logic        mem_we_i = 1'b0;
   logic [3:0]  mem_sel_i = '0;
   logic [31:0] mem_addr_i = '0;
   logic [31:0] mem_data_i = '0;
   logic        flush_i = 1'b0;
   logic [31:0] mem_data_o;
   logic        stallreq_o;
   int          n_chk = 0;
   int          n_err = 0;
   exp_t        sb[$];
   logic        prev_req = 1'b0;
   data_bus_if_if bus ();
   data_bus_if #(.TIMEOUT(TO), .CW(5)) dut (
      .clk(clk), .rst(rst), .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
      .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .flush_i(flush_i),
      .mem_data_o(mem_data_o), .stallreq_o(stallreq_o), .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] wd);
      mem_ce_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_sel_i = sel; mem_data_i = wd;
      sb.push_back('{we: we, addr: {addr[31:2], 2'b00}, sel: sel, wdata: wd});
   endtask
   always @(negedge clk) begin
      if (bus.req && !prev_req) begin
         if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("bus_we", {31'd0, bus.we}, {31'd0, e.we});
            chk("bus_addr", bus.addr, e.addr);
            chk("bus_sel", {28'd0, bus.sel}, {28'd0, e.sel});
            chk("bus_wdata", bus.wdata, e.wdata);
         end
      end
      prev_req <= bus.req;
   end
   task automatic run(input logic we, input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] wd,
                      input logic [31:0] rd, input int ack_at, input int flush_at, input int ncyc,
                      output int stall_n, output int req_n, output int rises, output int err_n,
                      output int hits, output logic [31:0] dor);
      logic live, pr;
      live = 1'b1; pr = 1'b0;
      stall_n = 0; req_n = 0; rises = 0; err_n = 0; hits = 0; dor = '0;
      issue(we, addr, sel, wd);
      for (int c = 0; c < ncyc; c++) begin
         mem_ce_i = live;
         bus.ack = (c == ack_at);
         bus.rdata = rd;
         flush_i = (c == flush_at);
         @(negedge clk);
         stall_n += int'(stallreq_o);
         req_n += int'(bus.req);
         rises += int'(bus.req & ~pr);
         pr = bus.req;
         err_n += int'(bus.err);
         hits += int'(mem_data_o != 0);
         dor |= mem_data_o;
         if (!stallreq_o || flush_i) live = 1'b0;
         cyc();
      end
      mem_ce_i = 1'b0; bus.ack = 1'b0; flush_i = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int s, r, ri, e, h;
      logic [31:0] d;
      bus.ack = 1'b0; bus.rdata = '0;
      cyc(); cyc();
      @(negedge clk);
      chk("rst_req", {31'd0, bus.req}, 32'd0);
      chk("rst_stall", {31'd0, stallreq_o}, 32'd0);
      chk("rst_data", mem_data_o, 32'd0);
      chk("rst_err", {31'd0, bus.err}, 32'd0);
      chk("rst_addr", bus.addr, 32'd0);
      rst = 1'b1;
      cyc();
      // load, ack in third WAIT cycle
      run(1'b0, 32'h0000_0104, 4'b1111, 32'h0, 32'hDEAD_BEEF, 3, -1, 7, s, r, ri, e, h, d);
      chk("ld_stall", s, 4); chk("ld_req", r, 3); chk("ld_rises", ri, 1);
      chk("ld_err", e, 0); chk("ld_hits", h, 1); chk("ld_data", d, 32'hDEAD_BEEF);
      // store byte, zero wait states
      run(1'b1, 32'h0000_0203, 4'b0001, 32'h5A5A_5A5A, 32'h1234_5678, 1, -1, 5, s, r, ri, e, h, d);
      chk("st_stall", s, 2); chk("st_req", r, 1); chk("st_hits", h, 0); chk("st_err", e, 0);
      // timeout: no ack ever
      run(1'b0, 32'h0000_0500, 4'b1111, 32'h0, 32'hFFFF_FFFF, -1, -1, TO + 6, s, r, ri, e, h, d);
      chk("to_stall", s, TO + 1); chk("to_req", r, TO); chk("to_err", e, 1);
      chk("to_hits", h, 0); chk("to_rises", ri, 1);
      // simultaneous ack and flush
      run(1'b0, 32'h0000_0600, 4'b1100, 32'h0, 32'hCAFE_F00D, 2, 2, 6, s, r, ri, e, h, d);
      chk("af_stall", s, 2); chk("af_req", r, 2); chk("af_err", e, 0); chk("af_hits", h, 0);
      // flush in WAIT cycle 2, new request arriving during DRAIN
      issue(1'b0, 32'h0000_0300, 4'b1111, 32'h0);
      bus.rdata = 32'hBAD0_BAD0;
      cyc();
      @(negedge clk); chk("fl_c1_stall", {31'd0, stallreq_o}, 32'd1);
      cyc(); flush_i = 1'b1;
      @(negedge clk); chk("fl_c2_stall", {31'd0, stallreq_o}, 32'd0); chk("fl_c2_req", {31'd0, bus.req}, 32'd1);
      cyc(); flush_i = 1'b0; issue(1'b1, 32'h0000_0401, 4'b0100, 32'h7777_7777);
      @(negedge clk); chk("dr_c3_stall", {31'd0, stallreq_o}, 32'd1); chk("dr_c3_req", {31'd0, bus.req}, 32'd1);
      cyc();
      @(negedge clk); chk("dr_c4_stall", {31'd0, stallreq_o}, 32'd1);
      cyc(); bus.ack = 1'b1;
      @(negedge clk); chk("dr_c5_req", {31'd0, bus.req}, 32'd1); chk("dr_c5_data", mem_data_o, 32'd0);
      cyc(); bus.ack = 1'b0;
      @(negedge clk); chk("dr_c6_req", {31'd0, bus.req}, 32'd0); chk("dr_c6_stall", {31'd0, stallreq_o}, 32'd1);
      chk("dr_c6_data", mem_data_o, 32'd0);
      cyc(); bus.ack = 1'b1;
      @(negedge clk); chk("dr_c7_req", {31'd0, bus.req}, 32'd1);
      cyc(); bus.ack = 1'b0;
      @(negedge clk); chk("dr_c8_stall", {31'd0, stallreq_o}, 32'd0); chk("dr_c8_data", mem_data_o, 32'd0);
      chk("dr_c8_err", {31'd0, bus.err}, 32'd0);
      cyc(); mem_ce_i = 1'b0;
      cyc();
      // async reset during WAIT
      issue(1'b0, 32'h0000_0040, 4'b1111, 32'h0);
      cyc(); cyc();
      @(negedge clk); chk("ar_req_pre", {31'd0, bus.req}, 32'd1); chk("ar_stall_pre", {31'd0, stallreq_o}, 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("ar_req", {31'd0, bus.req}, 32'd0); chk("ar_stall", {31'd0, stallreq_o}, 32'd0);
      chk("ar_data", mem_data_o, 32'd0);
      cyc(); mem_ce_i = 1'b0; rst = 1'b1;
      @(negedge clk); chk("ar_idle_req", {31'd0, bus.req}, 32'd0);
      cyc();
      run(1'b1, 32'h0000_0044, 4'b0011, 32'h0000_A5A5, 32'h0, 1, -1, 5, s, r, ri, e, h, d);
      chk("ar_st_stall", s, 2); chk("ar_st_req", r, 1);
      cyc();
      chk("sb_left", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
